// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_t;

   localparam int unsigned DATA_WIDTH_DEF    = 20;
   localparam int unsigned ADDRESS_WIDTH_DEF = 8;
   localparam int unsigned FIFO_DEPTH_DEF    = 4;

   localparam logic [DATA_WIDTH_DEF-1:0] HALT_WORD = '1;

   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// Synchronous FIFO (registered head, not fall-through) holding {pc, instr} entries.
module sync_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned WIDTH = 28,
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = count_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   output logic [CW-1:0]    o_count,
   output logic [WIDTH-1:0] o_head
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && (r_count != CW'(DEPTH));
   assign w_pop   = i_pop && (r_count != '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem    <= '{default: '0};
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding read tracking, buffering FIFO, redirect flush.
// Optional halt-on-all-ones-word support is enabled by defining FETCH_HALT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int unsigned ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
   parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   output logic                     imem_req,
   output logic [ADDRESS_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0]    imem_rdata,
   input  logic                     redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
   output logic                     instr_valid,
   output logic [DATA_WIDTH-1:0]    instr,
   output logic [ADDRESS_WIDTH-1:0] instr_pc,
   input  logic                     instr_ready,
   output logic                     halted
);

   localparam int unsigned CW = count_width(FIFO_DEPTH);
   localparam int unsigned EW = ADDRESS_WIDTH + DATA_WIDTH;

   fetch_state_t             r_state;
   logic                     r_halted;
   logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
   logic                     r_inflight;
   logic [ADDRESS_WIDTH-1:0] r_inflight_pc;

   logic [CW-1:0]            w_count;
   logic [CW:0]              w_occupancy;
   logic                     w_push;
   logic                     w_pop;
   logic [EW-1:0]            w_head;

   // Slots already claimed include the read still in flight, so a response always has room.
   assign w_occupancy = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
   assign imem_req    = !rst && (r_state == RUN) && !redirect_valid
                        && (w_occupancy < (CW+1)'(FIFO_DEPTH));
   assign imem_addr   = r_fetch_pc;

   assign w_push      = r_inflight && !redirect_valid;
   assign w_pop       = instr_valid && instr_ready && !redirect_valid;

   assign instr_valid = (w_count != '0);
   assign instr_pc    = w_head[EW-1:DATA_WIDTH];
   assign instr       = w_head[DATA_WIDTH-1:0];
   assign halted      = r_halted;

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (redirect_valid),
      .i_data  ({r_inflight_pc, imem_rdata}),
      .o_count (w_count),
      .o_head  (w_head)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= RUN;
         r_halted      <= 1'b0;
         r_fetch_pc    <= '0;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
      end else if (redirect_valid) begin
         r_state    <= RUN;
         r_halted   <= 1'b0;
         r_fetch_pc <= redirect_pc;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= imem_req;
         if (imem_req) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + ADDRESS_WIDTH'(1);
         end
`ifdef FETCH_HALT_EN
         // All-ones compare works for any DATA_WIDTH, matching HALT_WORD at the default width.
         if (w_push && (&imem_rdata)) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
         end
`endif
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {pc, instr} queued per redirect/reset, checked on each pop.
module tb_fetch_unit;

   localparam int unsigned DW    = 20;
   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [DW-1:0] imem_rdata = '0;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          instr_valid;
   logic [DW-1:0] instr;
   logic [AW-1:0] instr_pc;
   logic          instr_ready;
   logic          halted;

   int unsigned   n_total = 0;
   int unsigned   n_bad   = 0;
   int unsigned   delivered = 0;
   int unsigned   base;
   logic [AW-1:0] last_req_addr = '0;
   logic          halt_en = 1'b0;
   logic [AW-1:0] halt_addr = '0;
   logic [AW+DW-1:0] exp_q [$];

   fetch_unit #(
      .DATA_WIDTH    (DW),
      .ADDRESS_WIDTH (AW),
      .FIFO_DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      if (halt_en && (a == halt_addr)) return '1;
      return DW'(a) + DW'(20'h100);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_expected(input logic [AW-1:0] start);
      logic [AW-1:0] pc;
      exp_q.delete();
      for (int unsigned i = 0; i < 64; i++) begin
         pc = start + AW'(i);
         exp_q.push_back({pc, mem_word(pc)});
      end
   endtask

   task automatic do_redirect(input logic [AW-1:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      load_expected(target);
      tick(1);
      redirect_valid = 1'b0;
   endtask

   // Synchronous instruction memory, one-cycle read latency
   always @(posedge clk) begin
      if (imem_req) begin
         imem_rdata    <= mem_word(imem_addr);
         last_req_addr <= imem_addr;
      end
   end

   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      if (!rst && instr_valid && instr_ready && !redirect_valid) begin
         delivered++;
         if (exp_q.size() == 0) begin
            check("sb_extra", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("sb_pc", 32'(instr_pc), 32'(e[AW+DW-1:DW]));
            check("sb_instr", 32'(instr), 32'(e[DW-1:0]));
         end
      end
   end

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b1;
      tick(2);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_instr", 32'(instr), 32'd0);
      check("rst_pc", 32'(instr_pc), 32'd0);

      // 1: first fetch after reset, then one instruction per cycle
      load_expected('0);
      rst = 1'b0;
      tick(1);
      check("t1_not_yet", 32'(instr_valid), 32'd0);
      tick(1);
      check("t1_valid", 32'(instr_valid), 32'd1);
      check("t1_pc0", 32'(instr_pc), 32'd0);
      for (int unsigned i = 0; i < 4; i++) begin
         tick(1);
         check("t1_thru", 32'(instr_valid), 32'd1);
      end

      // 2: back-pressure fills the FIFO and stops requests
      instr_ready = 1'b0;
      do_redirect(8'h20);
      tick(10);
      check("t2_req_off", 32'(imem_req), 32'd0);
      check("t2_last_req", 32'(last_req_addr), 32'h20 + DEPTH - 1);
      check("t2_head_pc", 32'(instr_pc), 32'h20);
      check("t2_valid", 32'(instr_valid), 32'd1);
      base = delivered;
      instr_ready = 1'b1;
      tick(12);
      check("t2_drain_cnt", delivered - base, 32'd12);

      // 3: redirect with 3 buffered entries and one read in flight
      instr_ready = 1'b0;
      do_redirect(8'h30);
      tick(4);
      check("t3_head", 32'(instr_pc), 32'h30);
      instr_ready = 1'b1;
      do_redirect(8'h40);
      check("t3_flushed", 32'(instr_valid), 32'd0);
      tick(1);
      check("t3_gap", 32'(instr_valid), 32'd0);
      tick(1);
      check("t3_valid", 32'(instr_valid), 32'd1);
      check("t3_target", 32'(instr_pc), 32'h40);

      // 4: PC wraps past the top of the address space
      do_redirect(8'hFE);
      base = delivered;
      tick(8);
      check("t4_cnt", delivered - base, 32'd6);

      // 5: all-ones word in the stream
      halt_en   = 1'b1;
      halt_addr = 8'h53;
      do_redirect(8'h50);
      tick(8);
`ifdef FETCH_HALT_EN
      check("t5_halted", 32'(halted), 32'd1);
      check("t5_req_off", 32'(imem_req), 32'd0);
`else
      check("t5_not_halted", 32'(halted), 32'd0);
      check("t5_req_on", 32'(imem_req), 32'd1);
`endif
      halt_en = 1'b0;
      do_redirect(8'h10);
      check("t5_resume", 32'(halted), 32'd0);
      tick(2);
      check("t5_valid", 32'(instr_valid), 32'd1);
      check("t5_pc", 32'(instr_pc), 32'h10);

      // 6: asynchronous reset between edges mid-stream
      tick(3);
      #3;
      rst = 1'b1;
      #1;
      check("t6_valid", 32'(instr_valid), 32'd0);
      check("t6_req", 32'(imem_req), 32'd0);
      check("t6_halted", 32'(halted), 32'd0);
      exp_q.delete();
      tick(2);
      load_expected('0);
      rst = 1'b0;
      tick(1);
      check("t6_not_yet", 32'(instr_valid), 32'd0);
      tick(1);
      check("t6_valid_again", 32'(instr_valid), 32'd1);
      check("t6_pc0", 32'(instr_pc), 32'd0);
      tick(4);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
